// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned COUNT_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles little-endian bytes into a word; exposes the word including the
// byte being loaded so the caller can capture it on the same edge.
module byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_full_c
);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [WORD_W-1:0]     word_q;

  // Insert the incoming byte at the current lane.
  always_comb begin
    word_c = word_q;
    word_c[{idx_q, 3'b000} +: 8] = data;
  end

  assign word_full_c = load && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
    end else if (load) begin
      idx_q  <= idx_q + BYTE_IDX_W'(1);
      word_q <= word_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words,
// holding the CPU in reset for the duration of the session.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned SIZE   = 64,
  parameter int unsigned ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] widx_q, widx_d;
  logic [COUNT_W-1:0] widx_inc;
  logic [COUNT_W-1:0] len_c;
  logic               in_ready_d, we_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]  wa_d;
  logic [31:0]        wd_d;
  logic               accept_c;
  logic               pk_clear, pk_load;
  logic [WORD_W-1:0]  pk_word_c;
  logic               pk_full_c;

  assign accept_c = in_valid && in_ready;
  assign widx_inc = widx_q + COUNT_W'(1);
  assign len_c    = {in_data, count_q[7:0]};

  byte_to_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pk_clear),
    .load        (pk_load),
    .data        (in_data),
    .word_c      (pk_word_c),
    .word_full_c (pk_full_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    widx_d   = widx_q;
    we_d     = 1'b0;
    wa_d     = wa;
    wd_d     = wd;
    busy_d   = busy;
    done_d   = done;
    err_d    = err;
    pk_clear = 1'b0;
    pk_load  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept_c) begin
          count_d[7:0] = in_data;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept_c) begin
          count_d = len_c;
          if (len_c == '0) begin
            state_d = DONE;
          end else if (len_c > COUNT_W'(SIZE)) begin
            state_d = ERR;
          end else begin
            state_d  = DATA;
            widx_d   = '0;
            pk_clear = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          pk_load = 1'b1;
          if (pk_full_c) begin
            state_d = WRITE;
            we_d    = 1'b1;
            wa_d    = widx_q[ADDR_W-1:0];
            wd_d    = pk_word_c;
          end
        end
      end
      WRITE: begin
        widx_d  = widx_inc;
        state_d = (widx_inc == count_q) ? DONE : DATA;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      widx_q   <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
      in_ready <= in_ready_d;
      we       <= we_d;
      wa       <= wa_d;
      wd       <= wd_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      cpu_hold <= busy_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int unsigned SIZE   = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  int checks      = 0;
  int failures    = 0;
  int writes      = 0;
  int busy_cycles = 0;

  logic [ADDR_W+31:0] sb[$];

  always #5 clk = ~clk;

  imem_loader #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (we === 1'b1) begin
      logic [ADDR_W+31:0] e;
      writes++;
      chk("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write_addr_data", 64'({wa, wd}), 64'(e));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned stall, input bit noise);
    logic r = 1'b0;
    int   n;
    n = int'($urandom_range(stall, 0));
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      start    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) break;
    end
    in_valid = 1'b0;
    if (!r) chk("accept_timeout", 64'(r), 64'd1);
  endtask

  task automatic send_len(input logic [15:0] n, input int unsigned stall, input bit noise);
    send_byte(n[7:0], stall, noise);
    send_byte(n[15:8], stall, noise);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned stall, input bit noise);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall, noise);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic push(input int unsigned a, input logic [31:0] d);
    sb.push_back({ADDR_W'(a), d});
  endtask

  initial begin
    int w0;
    int b0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    chk("reset_outputs", 64'({in_ready, we, wa, wd, busy, done, err, cpu_hold}), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", 64'({in_ready, we, wa, wd, busy, done, err, cpu_hold}), 64'd0);

    // Two-word program, contiguous bytes.
    w0 = writes;
    push(0, 32'h00100513);
    push(1, 32'h00200593);
    pulse_start();
    chk("hold_after_start", 64'({busy, cpu_hold, in_ready}), 64'b111);
    send_len(16'd2, 0, 1'b0);
    send_word(32'h00100513, 0, 1'b0);
    chk("write_latency", 64'({we, wa, wd}), 64'({1'b1, ADDR_W'(0), 32'h00100513}));
    chk("hold_in_write", 64'(cpu_hold), 64'd1);
    send_word(32'h00200593, 0, 1'b0);
    wait_idle();
    chk("two_word_writes", 64'(writes - w0), 64'd2);
    chk("two_word_status", 64'({done, err, cpu_hold}), 64'b100);
    chk("hold_data_after", 64'({we, wa, wd}), 64'({1'b0, ADDR_W'(1), 32'h00200593}));

    // Zero length: done with no writes, busy for three cycles.
    w0 = writes;
    b0 = busy_cycles;
    pulse_start();
    chk("done_cleared_on_start", 64'(done), 64'd0);
    send_len(16'd0, 0, 1'b0);
    wait_idle();
    chk("zero_len_busy_cycles", 64'(busy_cycles - b0), 64'd3);
    chk("zero_len_writes", 64'(writes - w0), 64'd0);
    chk("zero_len_status", 64'({done, err}), 64'b10);

    // Oversize length aborts; next session clears err.
    w0 = writes;
    pulse_start();
    send_len(16'd65, 0, 1'b0);
    wait_idle();
    chk("oversize_writes", 64'(writes - w0), 64'd0);
    chk("oversize_status", 64'({done, err, cpu_hold}), 64'b010);
    pulse_start();
    chk("err_cleared_on_start", 64'(err), 64'd0);
    push(0, 32'hDEADBEEF);
    send_len(16'd1, 0, 1'b0);
    send_word(32'hDEADBEEF, 0, 1'b0);
    wait_idle();
    chk("after_err_status", 64'({done, err}), 64'b10);

    // Full-depth load.
    w0 = writes;
    pulse_start();
    send_len(16'd64, 0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      push(i, 32'(i));
      send_word(32'(i), 0, 1'b0);
    end
    wait_idle();
    chk("full_depth_writes", 64'(writes - w0), 64'd64);
    chk("full_depth_last", 64'({wa, wd}), 64'({ADDR_W'(63), 32'h0000003F}));
    chk("full_depth_status", 64'({done, err}), 64'b10);

    // Stalled stream with stray start pulses.
    w0 = writes;
    push(0, 32'h00100513);
    push(1, 32'h00200593);
    pulse_start();
    send_len(16'd2, 3, 1'b1);
    send_word(32'h00100513, 3, 1'b1);
    send_word(32'h00200593, 3, 1'b1);
    wait_idle();
    chk("stall_writes", 64'(writes - w0), 64'd2);
    chk("stall_status", 64'({done, err}), 64'b10);

    // Reset in the middle of word 1.
    push(0, 32'h11223344);
    pulse_start();
    send_len(16'd2, 0, 1'b0);
    send_word(32'h11223344, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    w0 = writes;
    rst = 1'b1;
    #1;
    chk("reset_midsession", 64'({in_ready, we, wa, wd, busy, done, err, cpu_hold}), 64'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("no_write_after_reset", 64'(writes - w0), 64'd0);
    chk("idle_after_reset", 64'({in_ready, busy}), 64'd0);
    push(0, 32'hCAFEF00D);
    pulse_start();
    send_len(16'd1, 0, 1'b0);
    send_word(32'hCAFEF00D, 0, 1'b0);
    wait_idle();
    chk("reload_writes", 64'(writes - w0), 64'd1);
    chk("reload_status", 64'({done, err}), 64'b10);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction ROM. Receives a byte stream and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into the instruction memory write port, starting at address 0.
- Holds the CPU in reset while loading, so a program can be replaced without re-synthesis.
- Sits between a byte source (UART receiver or testbench) and the instruction memory.

Parameters:
- SIZE, 64, instruction memory depth in 32-bit words.
- ADDR_W, $clog2(SIZE), word address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: one clock; asynchronous and active-high.
- start  input  1  one-cycle pulse that begins a load session. Ignored while busy.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- we  output  1  memory write enable, one-cycle pulse per word.
- wa  output  ADDR_W  memory word write address.
- wd  output  32  memory write data.
- busy  output  1  session in progress.
- done  output  1  sticky: last session completed successfully.
- err  output  1  sticky: last session aborted because the length was too large.
- cpu_hold  output  1  CPU reset request; equals busy.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, cpu_hold=0.
  - Reset mid-session aborts the session. No write is issued on the cycle reset is asserted.
- Outputs are registered. A byte transfer occurs only on a cycle where in_valid && in_ready.
- States and transitions:
  - IDLE: in_ready=0. On start → LEN_LO; clear done and err; set busy.
  - LEN_LO: in_ready=1. The accepted byte becomes count[7:0] → LEN_HI.
  - LEN_HI: in_ready=1. The accepted byte becomes count[15:8].
    - count==0 → DONE.
    - count>SIZE → ERR.
    - otherwise → DATA; byte index=0, word index=0.
  - DATA: in_ready=1. Accepted byte k (0..3) goes into wd[8k+7:8k], little-endian.
    - After byte 3, next state is WRITE.
  - WRITE: in_ready=0; we=1 for exactly one cycle; wa=word index.
    - Then word index increments.
    - If word index+1==count → DONE; else → DATA.
  - DONE: done=1, busy=0 → IDLE in the same transition (done stays sticky).
  - ERR: err=1, busy=0 → IDLE. No memory write is issued in an aborted session.
- Latency: we asserts on the cycle after the 4th byte of a word is accepted.
  - Maximum throughput is one word per 5 cycles.
- wa and wd hold their last values when we=0.
- Words beyond count are not written; memory above count keeps its old contents.
- Boundaries:
  - count==SIZE is legal; the final write is at wa=SIZE-1 with no wrap.
  - count==SIZE+1 → err.
  - in_valid low stalls any state indefinitely with no timeout.
  - start is ignored in every state except IDLE.
  - in_valid is ignored while in_ready=0.
  - start and reset together: reset wins.
- Arithmetic: count is 16-bit, word index is 16-bit, wa = word index[ADDR_W-1:0].

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR);
  - localparams for bytes-per-word (4) and count width (16).
- Natural sub-module: byte_to_word_packer. It holds a 2-bit byte index and a 32-bit shift/insert register and flags word_full.
  - The top-level FSM owns the count, the word index and the memory port.

Test Plan:
- Reset, then start, then bytes 02 00, 13 05 10 00, 93 05 20 00.
  - Expected: we pulses twice, (wa=0, wd=0x00100513) then (wa=1, wd=0x00200593).
  - done=1, err=0, cpu_hold high from the cycle after start until done.
- Length 00 00 → done=1 with no we pulse; busy lasts exactly 3 cycles after start.
- Length 0x0041 (65) with SIZE=64 → err=1, done=0, no we. A following valid session clears err.
- Length 0x0040 with 64 words of increasing pattern → last write at wa=63 with data 0x0000003F; no extra writes.
- in_valid toggled randomly during DATA, plus start pulses mid-session → the same words are written as in the contiguous case and the extra start pulses have no effect.
- Assert rst after the 2nd byte of word 1 → all outputs return to reset values immediately and no further we. A new session then loads correctly from wa=0.
